alu_shift_sequencer: RTL

// - Multi-bit shifter built on the single-bit shift ops of the shared ALU.
// - Takes a value, shift op and count. Loops the value through the ALU one bit per clock.
// - Ends with one OP_TEST pass to produce the final zero/neg flags.
// - Sits between the control unit and the ALU input mux; owns the ALU while busy.

---
 rtl/alu_shift_sequencer_if.sv | 70 +++++++
 rtl/alu_shift_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/alu_shift_sequencer_if.sv
// Shared types and the bundled control/ALU port interface for alu_shift_sequencer.
// The package comes first because the interface and the top module both depend on it.

package alu_shift_sequencer_pkg;

    localparam int unsigned REG_W    = 32;
    localparam int unsigned ALU_OP_W = 4;

    typedef logic [REG_W-1:0]    t_reg;
    typedef logic [ALU_OP_W-1:0] t_alu_op;

    localparam t_alu_op OP_TEST        = 4'h0;
    localparam t_alu_op OP_ADD         = 4'h1;
    localparam t_alu_op OP_SUB         = 4'h2;
    localparam t_alu_op OP_AND         = 4'h3;
    localparam t_alu_op OP_OR          = 4'h4;
    localparam t_alu_op OP_XOR         = 4'h5;
    localparam t_alu_op OP_LOGIC_LEFT  = 4'h8;
    localparam t_alu_op OP_LOGIC_RIGHT = 4'h9;
    localparam t_alu_op OP_ARITH_LEFT  = 4'hA;
    localparam t_alu_op OP_ARITH_RIGHT = 4'hB;

endpackage

// Control-unit request/response plus the ALU input mux and ALU flag return path.
interface alu_shift_sequencer_if #(
    parameter int unsigned COUNT_W = 5
);
    import alu_shift_sequencer_pkg::*;

    // control unit side
    logic               start;
    t_alu_op            shift_op;
    logic               rotate;
    t_reg               value;
    logic [COUNT_W-1:0] count;
    logic               busy;
    logic               done;
    t_reg               result;
    logic               carry_out;
    logic               zero_out;
    logic               neg_out;
    logic               over_out;

    // ALU side
    t_alu_op            alu_op;
    t_reg               alu_reg2;
    t_reg               alu_reg3;
    logic               alu_carry_in;
    t_reg               alu_result;
    logic               alu_carry;
    logic               alu_zero;
    logic               alu_neg;
    logic               alu_over;

    modport slave (
        input  start, shift_op, rotate, value, count,
        input  alu_result, alu_carry, alu_zero, alu_neg, alu_over,
        output alu_op, alu_reg2, alu_reg3, alu_carry_in,
        output busy, done, result, carry_out, zero_out, neg_out, over_out
    );

    modport master (
        output start, shift_op, rotate, value, count,
        output alu_result, alu_carry, alu_zero, alu_neg, alu_over,
        input  alu_op, alu_reg2, alu_reg3, alu_carry_in,
        input  busy, done, result, carry_out, zero_out, neg_out, over_out
    );

endinterface

// File: rtl/alu_shift_sequencer.sv
// Multi-bit shifter that loops an operand through the shared ALU one bit per clock,
// then runs a single OP_TEST pass to obtain the final zero/neg flags.
// Optional feature macro: ALU_SHIFT_ROTATE_EN -- when defined, rotate=1 with a
// logical shift op turns the shift into a rotate by re-inserting the carried-out bit.

module alu_shift_sequencer
    import alu_shift_sequencer_pkg::*;
#(
    parameter int unsigned COUNT_W = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    alu_shift_sequencer_if.slave   bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;

    logic [1:0]         state_q,     state_d;
    t_alu_op            op_q,        op_d;
    t_reg               work_q,      work_d;
    logic [COUNT_W-1:0] remaining_q, remaining_d;
    logic               carry_acc_q, carry_acc_d;
    logic               over_acc_q,  over_acc_d;
    t_alu_op            alu_op_q,    alu_op_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    t_reg               result_q,    result_d;
    logic               carry_q,     carry_d;
    logic               zero_q,      zero_d;
    logic               neg_q,       neg_d;
    logic               over_q,      over_d;
`ifdef ALU_SHIFT_ROTATE_EN
    logic               rot_q,       rot_d;
`endif

    function automatic logic is_shift_op(input t_alu_op op);
        return (op == OP_LOGIC_LEFT)  || (op == OP_LOGIC_RIGHT) ||
               (op == OP_ARITH_LEFT)  || (op == OP_ARITH_RIGHT);
    endfunction

    // Next-state and next-output logic for the IDLE -> SHIFT* -> FINAL sequence.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        work_d      = work_q;
        remaining_d = remaining_q;
        carry_acc_d = carry_acc_q;
        over_acc_d  = over_acc_q;
        result_d    = result_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        over_d      = over_q;
        done_d      = 1'b0;
`ifdef ALU_SHIFT_ROTATE_EN
        rot_d       = rot_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    work_d      = bus.value;
                    op_d        = bus.shift_op;
                    remaining_d = bus.count;
                    carry_acc_d = 1'b0;
                    over_acc_d  = 1'b0;
`ifdef ALU_SHIFT_ROTATE_EN
                    rot_d       = bus.rotate;
`endif
                    // Unsupported ops degrade to a zero-step shift.
                    if ((bus.count != '0) && is_shift_op(bus.shift_op)) begin
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_FINAL;
                    end
                end
            end
            S_SHIFT: begin
                work_d      = bus.alu_result;
`ifdef ALU_SHIFT_ROTATE_EN
                // Feed the bit that fell off back into the vacated end.
                if (rot_q && (op_q == OP_LOGIC_RIGHT)) begin
                    work_d = {bus.alu_carry, bus.alu_result[REG_W-2:0]};
                end else if (rot_q && (op_q == OP_LOGIC_LEFT)) begin
                    work_d = {bus.alu_result[REG_W-1:1], bus.alu_carry};
                end
`endif
                carry_acc_d = bus.alu_carry;
                over_acc_d  = over_acc_q | (bus.alu_over && (op_q == OP_ARITH_LEFT));
                remaining_d = remaining_q - COUNT_W'(1);
                if (remaining_q == COUNT_W'(1)) begin
                    state_d = S_FINAL;
                end
            end
            S_FINAL: begin
                result_d = work_q;
                zero_d   = bus.alu_zero;
                neg_d    = bus.alu_neg;
                carry_d  = carry_acc_q;
                over_d   = over_acc_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d   = (state_d != S_IDLE);
        alu_op_d = (state_d == S_SHIFT) ? op_d : OP_TEST;
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_TEST;
            work_q      <= '0;
            remaining_q <= '0;
            carry_acc_q <= 1'b0;
            over_acc_q  <= 1'b0;
            alu_op_q    <= OP_TEST;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            over_q      <= 1'b0;
`ifdef ALU_SHIFT_ROTATE_EN
            rot_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            work_q      <= work_d;
            remaining_q <= remaining_d;
            carry_acc_q <= carry_acc_d;
            over_acc_q  <= over_acc_d;
            alu_op_q    <= alu_op_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            over_q      <= over_d;
`ifdef ALU_SHIFT_ROTATE_EN
            rot_q       <= rot_d;
`endif
        end
    end

    // The working register doubles as the ALU reg2 operand.
    assign bus.alu_op       = alu_op_q;
    assign bus.alu_reg2     = work_q;
    assign bus.alu_reg3     = '0;
    assign bus.alu_carry_in = 1'b0;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.result       = result_q;
    assign bus.carry_out    = carry_q;
    assign bus.zero_out     = zero_q;
    assign bus.neg_out      = neg_q;
    assign bus.over_out     = over_q;

endmodule
